// File: rtl/routing_target_table.sv
// Programmable source-ID to source-route lookup table with a registered result stage.
// Optional hit/miss counters are enabled by defining ROUTE_TABLE_STATS_EN.
module routing_target_table #(
    parameter int          SRC_WD       = 4,
    parameter int          PATH_WD      = 7,
    parameter int          NUM_ENTRIES  = 8,
    parameter int          IDX_WD       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    parameter int unsigned DEFAULT_PATH = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lk_valid,
    output logic               lk_ready,
    input  logic [SRC_WD-1:0]  lk_addr,
    output logic               rs_valid,
    input  logic               rs_ready,
    output logic [PATH_WD-1:0] rs_path,
    output logic               rs_hit,
`ifdef ROUTE_TABLE_STATS_EN
    input  logic               stats_clr,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt,
`endif
    input  logic               cfg_we,
    input  logic [IDX_WD-1:0]  cfg_idx,
    input  logic [SRC_WD-1:0]  cfg_key,
    input  logic [PATH_WD-1:0] cfg_path,
    input  logic               cfg_en
);

    localparam logic [IDX_WD:0]    DEPTH    = (IDX_WD + 1)'(NUM_ENTRIES);
    localparam logic [PATH_WD-1:0] DEF_PATH = PATH_WD'(DEFAULT_PATH);

    logic [NUM_ENTRIES-1:0] ent_vld;
    logic [SRC_WD-1:0]      ent_key  [NUM_ENTRIES];
    logic [PATH_WD-1:0]     ent_path [NUM_ENTRIES];

    logic               cfg_ok;
    logic               lk_xfer;
    logic               mt_hit;
    logic [PATH_WD-1:0] mt_path;

    // Depth may be a non-power-of-two, so out-of-range indices are dropped.
    assign cfg_ok   = cfg_we && !rst && ({1'b0, cfg_idx} < DEPTH);
    assign lk_ready = !rst && (!rs_valid || rs_ready);
    assign lk_xfer  = lk_valid && lk_ready;

    // Scan from the top so the lowest matching index is the last to win.
    always_comb begin
        mt_hit  = 1'b0;
        mt_path = DEF_PATH;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_vld[i] && (ent_key[i] == lk_addr)) begin
                mt_hit  = 1'b1;
                mt_path = ent_path[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld <= '0;
        end else if (cfg_ok) begin
            ent_vld[cfg_idx] <= cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            ent_key[cfg_idx]  <= cfg_key;
            ent_path[cfg_idx] <= cfg_path;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_valid <= 1'b0;
            rs_path  <= '0;
            rs_hit   <= 1'b0;
        end else if (lk_xfer) begin
            rs_valid <= 1'b1;
            rs_path  <= mt_path;
            rs_hit   <= mt_hit;
        end else if (rs_ready) begin
            rs_valid <= 1'b0;
        end
    end

`ifdef ROUTE_TABLE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (lk_xfer) begin
            if (mt_hit) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_routing_target_table.sv
// Directed bench for routing_target_table: lookup, priority, write/lookup
// ordering, backpressure, mid-operation reset and optional counters.
module tb_routing_target_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       lk_valid;
    logic       lk_ready;
    logic [3:0] lk_addr;
    logic       rs_valid;
    logic       rs_ready;
    logic [6:0] rs_path;
    logic       rs_hit;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_key;
    logic [6:0] cfg_path;
    logic       cfg_en;
`ifdef ROUTE_TABLE_STATS_EN
    logic        stats_clr;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    routing_target_table dut (
        .clk      (clk),
        .rst      (rst),
        .lk_valid (lk_valid),
        .lk_ready (lk_ready),
        .lk_addr  (lk_addr),
        .rs_valid (rs_valid),
        .rs_ready (rs_ready),
        .rs_path  (rs_path),
        .rs_hit   (rs_hit),
`ifdef ROUTE_TABLE_STATS_EN
        .stats_clr(stats_clr),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_key  (cfg_key),
        .cfg_path (cfg_path),
        .cfg_en   (cfg_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [3:0] key,
                             input logic [6:0] path, input logic en);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_key  = key;
        cfg_path = path;
        cfg_en   = en;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; lk_valid = 1'b0; lk_addr = '0; rs_ready = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; cfg_path = '0; cfg_en = 1'b0;
`ifdef ROUTE_TABLE_STATS_EN
        stats_clr = 1'b0;
`endif
        tick(); tick();
        n_vec++;
        if (lk_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_lk_ready got %b want 0", lk_ready);
        end
        n_vec++;
        if (rs_valid !== 1'b0 || rs_path !== 7'd0 || rs_hit !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rs got v=%b p=%b h=%b want 0/0/0", rs_valid, rs_path, rs_hit);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (lk_ready !== 1'b1 || rs_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst got rdy=%b v=%b want 1/0", lk_ready, rs_valid);
        end
    endtask

    task automatic test_basic();
        cfg_write(3'd0, 4'h2, 7'b0000000, 1'b1);
        cfg_write(3'd1, 4'h4, 7'b0000001, 1'b1);
        cfg_write(3'd2, 4'h7, 7'b0000010, 1'b1);
        cfg_write(3'd3, 4'ha, 7'b0000100, 1'b1);
        cfg_write(3'd4, 4'hd, 7'b0011101, 1'b1);
        rs_ready = 1'b1;
        lk_valid = 1'b1; lk_addr = 4'hd;
        tick();
        n_vec++;
        if (rs_valid !== 1'b1 || rs_path !== 7'b0011101 || rs_hit !== 1'b1) begin
            n_err++;
            $display("FAIL lookup_d got v=%b p=%b h=%b want 1/0011101/1", rs_valid, rs_path, rs_hit);
        end
        lk_addr = 4'h7;
        n_vec++;
        if (lk_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ready got %b want 1", lk_ready);
        end
        tick();
        n_vec++;
        if (rs_valid !== 1'b1 || rs_path !== 7'b0000010 || rs_hit !== 1'b1) begin
            n_err++;
            $display("FAIL lookup_7 got v=%b p=%b h=%b want 1/0000010/1", rs_valid, rs_path, rs_hit);
        end
        lk_valid = 1'b0;
        tick();
        n_vec++;
        if (rs_valid !== 1'b0) begin
            n_err++; $display("FAIL drain got v=%b want 0", rs_valid);
        end
    endtask

    task automatic test_miss();
        lk_valid = 1'b1; lk_addr = 4'h3;
        tick();
        lk_valid = 1'b0;
        n_vec++;
        if (rs_valid !== 1'b1 || rs_path !== 7'd0 || rs_hit !== 1'b0) begin
            n_err++;
            $display("FAIL miss_3 got v=%b p=%b h=%b want 1/0000000/0", rs_valid, rs_path, rs_hit);
        end
        tick();
    endtask

    task automatic test_priority();
        cfg_write(3'd5, 4'h4, 7'b0110011, 1'b1);
        lk_valid = 1'b1; lk_addr = 4'h4;
        tick();
        lk_valid = 1'b0;
        n_vec++;
        if (rs_path !== 7'b0000001 || rs_hit !== 1'b1) begin
            n_err++;
            $display("FAIL prio_low got p=%b h=%b want 0000001/1", rs_path, rs_hit);
        end
        tick();
        cfg_write(3'd1, 4'h4, 7'b1111111, 1'b0);
        lk_valid = 1'b1; lk_addr = 4'h4;
        tick();
        lk_valid = 1'b0;
        n_vec++;
        if (rs_path !== 7'b0110011 || rs_hit !== 1'b1) begin
            n_err++;
            $display("FAIL prio_inval got p=%b h=%b want 0110011/1", rs_path, rs_hit);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        cfg_we = 1'b1; cfg_idx = 3'd6; cfg_key = 4'h6;
        cfg_path = 7'b1000000; cfg_en = 1'b1;
        lk_valid = 1'b1; lk_addr = 4'h6;
        tick();
        cfg_we = 1'b0;
        n_vec++;
        if (rs_valid !== 1'b1 || rs_path !== 7'd0 || rs_hit !== 1'b0) begin
            n_err++;
            $display("FAIL wr_same got v=%b p=%b h=%b want 1/0000000/0", rs_valid, rs_path, rs_hit);
        end
        tick();
        lk_valid = 1'b0;
        n_vec++;
        if (rs_valid !== 1'b1 || rs_path !== 7'b1000000 || rs_hit !== 1'b1) begin
            n_err++;
            $display("FAIL wr_next got v=%b p=%b h=%b want 1/1000000/1", rs_valid, rs_path, rs_hit);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        rs_ready = 1'b1;
        lk_valid = 1'b1; lk_addr = 4'hd;
        tick();
        rs_ready = 1'b0; lk_addr = 4'h7;
        #1;
        n_vec++;
        if (lk_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_ready got %b want 0", lk_ready);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) cfg_write(3'd7, 4'hd, 7'b1111111, 1'b1);
            else tick();
            n_vec++;
            if (rs_valid !== 1'b1 || rs_path !== 7'b0011101 || lk_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d got v=%b p=%b rdy=%b want 1/0011101/0",
                         i, rs_valid, rs_path, lk_ready);
            end
        end
        rs_ready = 1'b1;
        tick();
        n_vec++;
        if (rs_valid !== 1'b1 || rs_path !== 7'b0000010) begin
            n_err++;
            $display("FAIL release_7 got v=%b p=%b want 1/0000010", rs_valid, rs_path);
        end
        lk_addr = 4'ha;
        tick();
        n_vec++;
        if (rs_valid !== 1'b1 || rs_path !== 7'b0000100) begin
            n_err++;
            $display("FAIL release_a got v=%b p=%b want 1/0000100", rs_valid, rs_path);
        end
        lk_valid = 1'b0;
        tick();
        n_vec++;
        if (rs_valid !== 1'b0) begin
            n_err++; $display("FAIL release_drain got v=%b want 0", rs_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] keys [4];
        keys[0] = 4'h2; keys[1] = 4'h6; keys[2] = 4'hd; keys[3] = 4'h4;
        rs_ready = 1'b0;
        lk_valid = 1'b1; lk_addr = 4'h2;
        tick();
        n_vec++;
        if (rs_valid !== 1'b1 || rs_hit !== 1'b1) begin
            n_err++;
            $display("FAIL pre_rst got v=%b h=%b want 1/1", rs_valid, rs_hit);
        end
        rst = 1'b1; lk_addr = 4'h7;
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_key = 4'h2; cfg_path = 7'b0000101; cfg_en = 1'b1;
        tick();
        cfg_we = 1'b0;
        n_vec++;
        if (rs_valid !== 1'b0 || lk_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst got v=%b rdy=%b want 0/0", rs_valid, lk_ready);
        end
        rst = 1'b0; rs_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lk_addr = keys[i];
            tick();
            n_vec++;
            if (rs_valid !== 1'b1 || rs_hit !== 1'b0 || rs_path !== 7'd0) begin
                n_err++;
                $display("FAIL rst_miss%0d got v=%b p=%b h=%b want 1/0000000/0",
                         i, rs_valid, rs_path, rs_hit);
            end
        end
        lk_valid = 1'b0;
        tick();
    endtask

`ifdef ROUTE_TABLE_STATS_EN
    task automatic test_stats();
        logic [3:0] keys [5];
        keys[0] = 4'h1; keys[1] = 4'h2; keys[2] = 4'h1; keys[3] = 4'h3; keys[4] = 4'h4;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        cfg_write(3'd0, 4'h1, 7'b0000001, 1'b1);
        cfg_write(3'd1, 4'h2, 7'b0000010, 1'b1);
        rs_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lk_valid = 1'b1; lk_addr = keys[i];
            tick();
        end
        lk_valid = 1'b0;
        n_vec++;
        if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL stats_cnt got h=%0d m=%0d want 3/2", hit_cnt, miss_cnt);
        end
        stats_clr = 1'b1; lk_valid = 1'b1; lk_addr = 4'h1;
        tick();
        stats_clr = 1'b0; lk_valid = 1'b0;
        n_vec++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || rs_hit !== 1'b1) begin
            n_err++;
            $display("FAIL stats_clr got h=%0d m=%0d rh=%b want 0/0/1", hit_cnt, miss_cnt, rs_hit);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_miss();
        test_priority();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
`ifdef ROUTE_TABLE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
